alu_issue_unit: RTL and testbench
=================================

// Module: alu_issue_unit
// PURPOSE
//  Upstream issue stage for the 8-bit ALU. Accepts operation requests (opcode, A, B) on a valid/ready
//  interface and buffers them in a small FIFO. Issues one request at a time to the combinational ALU,
//  then registers the ALU result and flags and holds them on a valid/ready response port.
//  Sits between the instruction source and the ALU; the ALU is instantiated by the parent, not in here.
// PARAMETERS
//  DEPTH   4   request FIFO entries; power of two, >=2
//  DATA_W  8   operand/result width; fixed at 8 to match the ALU
// PORTS
//  clk         in   1       single clock, all state on rising edge
//  rst         in   1       synchronous reset, active-high
//  in_valid    in   1       request valid
//  in_ready    out  1       FIFO can accept (count < DEPTH)
//  in_opcode   in   3       ALU opcode
//  in_a        in   DATA_W  operand A
//  in_b        in   DATA_W  operand B
//  in_use_acc  in   1       take A from accumulator (only with ALU_ACC_FWD_EN)
//  alu_opcode  out  3       to ALU opcode
//  alu_a       out  DATA_W  to ALU A_in
//  alu_b       out  DATA_W  to ALU B_in
//  alu_result  in   DATA_W  from ALU salida
//  alu_flags   in   8       from ALU flags
//  out_valid   out  1       response valid
//  out_ready   in   1       response accepted
//  out_result  out  DATA_W  registered result
//  out_flags   out  8       registered flags, passed through bit-exact
//  fifo_count  out  $clog2(DEPTH)+1  entries buffered
//  busy        out  1       FSM != IDLE or fifo_count != 0
// BEHAVIOUR
//  - Reset (rst=1 at edge): FIFO empty, fifo_count=0, FSM=IDLE, out_valid=0, out_result=0, out_flags=0,
//    accumulator=0. alu_* outputs are 0 whenever FSM != ISSUE. Reset mid-operation drops all queued
//    and in-flight requests, including any held response.
//  - Push when in_valid && in_ready. in_ready is purely count < DEPTH; no bypass when full, even if a pop
//    happens in the same cycle.
//  - Push and pop in the same cycle: count unchanged, pointers wrap modulo DEPTH.
//  - FSM:
//    IDLE  -> ISSUE when count != 0.
//    ISSUE (exactly 1 cycle): alu_* driven from the FIFO head. At the edge, capture
//          out_result <= alu_result and out_flags <= alu_flags, pop the head, go to RESP.
//    RESP: out_valid=1, outputs stable. On out_valid && out_ready, go to ISSUE if the count after this
//          edge is != 0, else go to IDLE.
//  - Latency: a request pushed at edge N into an empty unit is in ISSUE during cycle N+1 and has
//    out_valid=1 from cycle N+2. Throughput is at most 1 op per 2 cycles.
//  - Ordering: responses are strictly in request order; no request is dropped under backpressure.
//  - Arithmetic is performed only by the ALU; this block adds no width extension and never modifies
//    the flags.
// CONFIGURATION
//  ALU_ACC_FWD_EN defined:
//    - The accumulator is loaded with alu_result at every ISSUE edge.
//    - If the head entry has use_acc=1, alu_a = accumulator instead of the stored A.
//    - use_acc is stored in the FIFO entry.
//  ALU_ACC_FWD_EN not defined:
//    - in_use_acc is ignored and not stored; no accumulator register.
//    - alu_a is always the stored A.
// STRUCTURE
//  - alu_pkg:
//    - opcode typedef/enum (ADD2C=000, SUB2C, ADDMAG, SUBMAG, SHL, SHR, MULPOW2, DIVPOW2)
//    - flag bit index constants (N=7, Z=6, C=5, V=4, G=3, Q=2, O=1, P=0)
//    - FSM state enum {IDLE, ISSUE, RESP}
//    - request entry struct
//  - Sub-module alu_req_fifo: parametrised sync FIFO with push/pop/count/full/empty.
// TESTING (bench instantiates the real ALU behind this unit)
//  1. Single op 010, A=5, B=3 -> out_valid on 2nd cycle after push; result 0x08, flags 0x08 (G only).
//  2. Op 011, A=3, B=3 -> result 0x00, flags 0x44 (Z,Q).
//  3. out_ready=0, push 4 ops -> in_ready=0 at count=4, 5th request stalls; release out_ready ->
//     4 responses in order, nothing lost or duplicated.
//  4. Push on the same cycle as the RESP handshake at count=4 -> request is not accepted, count stays 4.
//  5. rst asserted during RESP with 3 queued -> next cycle out_valid=0, fifo_count=0, busy=0, alu_*=0.
//  6. (ALU_ACC_FWD_EN) op 010 A=5 B=3, then op 010 use_acc=1 A=0xFF B=2 -> results 0x08, 0x0A.
//     Without the macro -> 0x08, 0x01.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcodes, flag bit positions, FSM states and the queued request.
// ALU_ACC_FWD_EN adds a use_acc bit to each queued request.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [2:0] {
    OP_ADD2C   = 3'b000,
    OP_SUB2C   = 3'b001,
    OP_ADDMAG  = 3'b010,
    OP_SUBMAG  = 3'b011,
    OP_SHL     = 3'b100,
    OP_SHR     = 3'b101,
    OP_MULPOW2 = 3'b110,
    OP_DIVPOW2 = 3'b111
  } opcode_e;

  localparam int FLAG_N = 7;
  localparam int FLAG_Z = 6;
  localparam int FLAG_C = 5;
  localparam int FLAG_V = 4;
  localparam int FLAG_G = 3;
  localparam int FLAG_Q = 2;
  localparam int FLAG_O = 1;
  localparam int FLAG_P = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
`ifdef ALU_ACC_FWD_EN
    logic             use_acc;
`endif
    logic [2:0]       opcode;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } req_t;

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO with combinational head read, so the issue cycle can drive the ALU directly.
module alu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/alu_issue_unit.sv
// Issue stage for the 8-bit ALU: buffers requests, issues one per ISSUE cycle, holds the registered response.
// Optional ALU_ACC_FWD_EN forwards the last ALU result as operand A for requests tagged use_acc.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_opcode,
  input  logic [DATA_W-1:0]       in_a,
  input  logic [DATA_W-1:0]       in_b,
  input  logic                    in_use_acc,
  output logic [2:0]              alu_opcode,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  input  logic [DATA_W-1:0]       alu_result,
  input  logic [7:0]              alu_flags,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_result,
  output logic [7:0]              out_flags,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    busy
);

  state_e            state_q, state_d;
  req_t              wr_entry, head;
  logic              push, pop, full, empty;
  logic [DATA_W-1:0] result_q;
  logic [7:0]        flags_q;
  logic [DATA_W-1:0] head_a;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == ST_ISSUE);

  always_comb begin
    wr_entry        = '0;
    wr_entry.opcode = in_opcode;
    wr_entry.a      = in_a;
    wr_entry.b      = in_b;
`ifdef ALU_ACC_FWD_EN
    wr_entry.use_acc = in_use_acc;
`endif
  end

  alu_req_fifo #(.DEPTH(DEPTH), .W($bits(req_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

`ifdef ALU_ACC_FWD_EN
  logic [DATA_W-1:0] acc_q;

  always_ff @(posedge clk) begin
    if (rst)                    acc_q <= '0;
    else if (state_q == ST_ISSUE) acc_q <= alu_result;
  end

  assign head_a = head.use_acc ? acc_q : head.a;
`else
  logic unused_use_acc;
  assign unused_use_acc = in_use_acc;
  assign head_a         = head.a;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Leaving RESP looks at the count after this edge, so a same-cycle push counts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!empty) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  if (out_ready) state_d = (!empty || push) ? ST_ISSUE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_opcode = '0;
    alu_a      = '0;
    alu_b      = '0;
    out_valid  = (state_q == ST_RESP);
    if (state_q == ST_ISSUE) begin
      alu_opcode = head.opcode;
      alu_a      = head_a;
      alu_b      = head.b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (state_q == ST_ISSUE) begin
      result_q <= alu_result;
      flags_q  <= alu_flags;
    end
  end

  assign out_result = result_q;
  assign out_flags  = flags_q;
  assign busy       = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural 8-bit ALU wired behind it.
// Expected values for the forwarding test follow ALU_ACC_FWD_EN.
module tb_alu_issue_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_use_acc;
  logic [2:0] in_opcode;
  logic [7:0] in_a, in_b;
  logic [2:0] alu_opcode;
  logic [7:0] alu_a, alu_b, alu_result, alu_flags;
  logic       out_valid, out_ready;
  logic [7:0] out_result, out_flags;
  logic [2:0] fifo_count;
  logic       busy;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.DEPTH(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_use_acc (in_use_acc),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  // Behavioural ALU: flags {N,Z,C,V,G,Q,O,P}
  logic [8:0] alu_sum;
  logic [7:0] alu_r;
  logic       alu_c, alu_v;
  always_comb begin
    alu_sum = 9'd0;
    alu_r   = 8'd0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_opcode)
      3'b000: begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r   = alu_sum[7:0];
        alu_c   = alu_sum[8];
        alu_v   = (alu_a[7] == alu_b[7]) && (alu_r[7] != alu_a[7]);
      end
      3'b001: begin
        alu_sum = {1'b0, alu_a} - {1'b0, alu_b};
        alu_r   = alu_sum[7:0];
        alu_c   = alu_sum[8];
        alu_v   = (alu_a[7] != alu_b[7]) && (alu_r[7] != alu_a[7]);
      end
      3'b010: begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r   = alu_sum[7:0];
        alu_c   = alu_sum[8];
      end
      3'b011: alu_r = (alu_a >= alu_b) ? (alu_a - alu_b) : (alu_b - alu_a);
      3'b100: begin alu_r = alu_a << 1; alu_c = alu_a[7]; end
      3'b101: begin alu_r = alu_a >> 1; alu_c = alu_a[0]; end
      3'b110: alu_r = alu_a << alu_b[2:0];
      default: alu_r = alu_a >> alu_b[2:0];
    endcase
    alu_result = alu_r;
    alu_flags  = {alu_r[7], (alu_r == 8'd0), alu_c, alu_v,
                  (alu_a > alu_b), (alu_a == alu_b), 1'b0, 1'b0};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic acc);
    in_valid   = v;
    in_opcode  = op;
    in_a       = a;
    in_b       = b;
    in_use_acc = acc;
  endtask

  // Collects n responses with out_ready held high, comparing against exp[first..first+n-1].
  task automatic drain(input string tag, input int first, input int n, input logic [7:0] exp [8]);
    int got;
    got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got < n; c++) begin
      tick();
      if (out_valid) begin
        check($sformatf("%s_result%0d", tag, first + got), {24'd0, out_result}, {24'd0, exp[first + got]});
        got++;
      end
    end
    check({tag, "_count"}, got, n);
  endtask

  logic [7:0] exp_burst [8];
  logic [7:0] exp_fwd   [8];

  initial begin
    exp_burst = '{8'h03, 8'h05, 8'h02, 8'h08, 8'h0C, 8'h00, 8'h00, 8'h00};
`ifdef ALU_ACC_FWD_EN
    exp_fwd   = '{8'h08, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    exp_fwd   = '{8'h08, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    rst       = 1'b1;
    out_ready = 1'b0;
    set_req(1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", out_result, 0);
    check("rst_flags", out_flags, 0);
    check("rst_alu_a", alu_a, 0);

    // Single ADDMAG 5+3
    set_req(1'b1, 3'b010, 8'd5, 8'd3, 1'b0);
    tick();
    set_req(1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
    check("t1_count", fifo_count, 1);
    check("t1_valid_c0", out_valid, 0);
    tick();
    check("t1_alu_op", alu_opcode, 3'b010);
    check("t1_alu_a", alu_a, 5);
    check("t1_alu_b", alu_b, 3);
    check("t1_valid_c1", out_valid, 0);
    tick();
    check("t1_valid_c2", out_valid, 1);
    check("t1_result", out_result, 8'h08);
    check("t1_flags", out_flags, 8'h08);
    check("t1_alu_idle", alu_a, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_done_valid", out_valid, 0);
    check("t1_done_busy", busy, 0);

    // SUBMAG 3-3
    set_req(1'b1, 3'b011, 8'd3, 8'd3, 1'b0);
    tick();
    set_req(1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
    tick();
    tick();
    check("t2_valid", out_valid, 1);
    check("t2_result", out_result, 8'h00);
    check("t2_flags", out_flags, 8'h44);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Backpressure burst: five pushes fill the FIFO behind one held response
    set_req(1'b1, 3'b000, 8'd1, 8'd2, 1'b0);    tick();
    set_req(1'b1, 3'b001, 8'd9, 8'd4, 1'b0);    tick();
    set_req(1'b1, 3'b100, 8'h81, 8'd0, 1'b0);   tick();
    set_req(1'b1, 3'b101, 8'h10, 8'd0, 1'b0);   tick();
    set_req(1'b1, 3'b110, 8'd3, 8'd2, 1'b0);    tick();
    check("t3_count_full", fifo_count, 4);
    check("t3_in_ready", in_ready, 0);
    set_req(1'b1, 3'b111, 8'h80, 8'd1, 1'b0);
    tick();
    tick();
    check("t3_stall_count", fifo_count, 4);
    check("t3_stall_valid", out_valid, 1);
    check("t3_first_result", out_result, exp_burst[0]);

    // Handshake with a push attempt at count=4: push refused
    out_ready = 1'b1;
    tick();
    set_req(1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
    check("t4_count", fifo_count, 4);
    check("t4_valid", out_valid, 0);
    drain("t3", 1, 4, exp_burst);
    tick();
    check("t3_idle_busy", busy, 0);
    out_ready = 1'b0;

    // Reset while a response is held with three queued
    set_req(1'b1, 3'b000, 8'd1, 8'd1, 1'b0); tick();
    set_req(1'b1, 3'b000, 8'd2, 8'd2, 1'b0); tick();
    set_req(1'b1, 3'b000, 8'd3, 8'd3, 1'b0); tick();
    set_req(1'b1, 3'b000, 8'd4, 8'd4, 1'b0); tick();
    set_req(1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
    check("t5_pre_valid", out_valid, 1);
    check("t5_pre_count", fifo_count, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_valid", out_valid, 0);
    check("t5_count", fifo_count, 0);
    check("t5_busy", busy, 0);
    check("t5_alu", {alu_opcode, alu_a, alu_b}, 0);
    check("t5_result", out_result, 0);

    // Accumulator forwarding (or plain A without the option)
    out_ready = 1'b1;
    set_req(1'b1, 3'b010, 8'd5, 8'd3, 1'b0);   tick();
    set_req(1'b1, 3'b010, 8'hFF, 8'd2, 1'b1);  tick();
    set_req(1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
    drain("t6", 0, 2, exp_fwd);
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
